// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared types and constants for the AXI-side completion path
package apb2axi_pkg;
  localparam int TAG_W = 4;
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic is_write;
    logic error;
    logic [1:0] resp;
    logic [7:0] num_beats;
  } completion_entry_t;
  localparam int COMPLETION_W = $bits(completion_entry_t);
endpackage

// File: rtl/apb2axi_cpl_fifo.sv
// apb2axi_cpl_fifo: single-push/single-pop synchronous FIFO with occupancy count
module apb2axi_cpl_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign head = mem[rd_ptr];
  // storage, power-of-two pointers wrap on their own, count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= push_data;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/apb2axi_response_handler.sv
// apb2axi_response_handler: merges AXI R/B traffic into one per-transaction completion stream
module apb2axi_response_handler
  import apb2axi_pkg::*;
#(
  parameter int CPL_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [TAG_W-1:0]        rid,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [TAG_W-1:0]        bid,
  input  logic [1:0]              bresp,
  output logic                    gw_cpl_valid,
  output logic [COMPLETION_W-1:0] gw_cpl_data,
  input  logic                    gw_cpl_ready
);
  localparam int CW = $clog2(CPL_DEPTH) + 1;
  logic [7:0] beat_cnt [NUM_TAGS];
  logic [1:0] worst_resp [NUM_TAGS];
  logic [NUM_TAGS-1:0] ovf;
  logic [CW-1:0] count;
  logic rr_prio, free, grant_r, grant_b, r_acc, b_acc, push;
  logic [1:0] resp_max;
  completion_entry_t r_ent, b_ent, push_ent;
  assign free = count < CW'(CPL_DEPTH);
  assign gw_cpl_valid = count != '0;
  // arbitration between a finishing read and a write response; non-last R beats never need a slot
  always_comb begin
    grant_r = !bvalid || rr_prio;
    grant_b = !(rvalid && rlast) || !rr_prio;
    rready = !areset && (!rlast || (free && grant_r));
    bready = !areset && free && grant_b;
    r_acc = rvalid && rready;
    b_acc = bvalid && bready;
    push = (r_acc && rlast) || b_acc;
    resp_max = rresp > worst_resp[rid] ? rresp : worst_resp[rid];
    r_ent = '{tag: rid, is_write: 1'b0, error: resp_max[1] | ovf[rid], resp: resp_max, num_beats: beat_cnt[rid]};
    b_ent = '{tag: bid, is_write: 1'b1, error: bresp[1], resp: bresp, num_beats: 8'd0};
    push_ent = b_acc ? b_ent : r_ent;
  end
  // round-robin pointer moves only when both sides contend for a free slot
  always_ff @(posedge aclk) begin
    if (areset) rr_prio <= 1'b0;
    else if (rvalid && rlast && bvalid && free) rr_prio <= !rr_prio;
  end
  // per-tag beat count, worst response and overflow; cleared when the last beat completes
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        beat_cnt[i] <= '0;
        worst_resp[i] <= '0;
      end
      ovf <= '0;
    end else if (r_acc && rlast) begin
      beat_cnt[rid] <= '0;
      worst_resp[rid] <= '0;
      ovf[rid] <= 1'b0;
    end else if (r_acc) begin
      if (beat_cnt[rid] == 8'hFF) ovf[rid] <= 1'b1;
      else beat_cnt[rid] <= beat_cnt[rid] + 8'd1;
      worst_resp[rid] <= resp_max;
    end
  end
  apb2axi_cpl_fifo #(.W(COMPLETION_W), .DEPTH(CPL_DEPTH)) u_fifo (
    .clk(aclk),
    .rst(areset),
    .push(push),
    .push_data(push_ent),
    .pop(gw_cpl_ready),
    .count(count),
    .head(gw_cpl_data)
  );
endmodule

// File: tb/tb_apb2axi_response_handler.sv
// tb_apb2axi_response_handler: randomized and directed scoreboard bench for the response handler
module tb_apb2axi_response_handler;
  import apb2axi_pkg::*;
  logic aclk = 1'b0, areset = 1'b1, rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0, gw_cpl_ready = 1'b0;
  logic [TAG_W-1:0] rid = '0, bid = '0;
  logic [1:0] rresp = '0, bresp = '0;
  logic rready, bready, gw_cpl_valid;
  logic [COMPLETION_W-1:0] gw_cpl_data;
  int checks = 0, passes = 0, occ = 0;
  bit prio = 1'b0;
  int nbeats [NUM_TAGS];
  logic [1:0] worst [NUM_TAGS];
  completion_entry_t exp_q [$];

  apb2axi_response_handler dut (
    .aclk(aclk), .areset(areset),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rlast(rlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .gw_cpl_valid(gw_cpl_valid), .gw_cpl_data(gw_cpl_data), .gw_cpl_ready(gw_cpl_ready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic completion_entry_t mk(input logic [TAG_W-1:0] t, input logic w, input logic e,
                                           input logic [1:0] r, input int nb);
    completion_entry_t c;
    c.tag = t;
    c.is_write = w;
    c.error = e;
    c.resp = r;
    c.num_beats = 8'(nb);
    return c;
  endfunction

  // one clock of the reference model: expected readies, accepted beats, expected completions
  task automatic tick(output bit ra, output bit ba);
    bit fr, er, eb;
    logic [1:0] m;
    int pop;
    @(negedge aclk);
    fr = occ < 4;
    er = !rlast || (fr && (!bvalid || prio));
    eb = fr && (!(rvalid && rlast) || !prio);
    check("rready", 32'(rready), 32'(er));
    check("bready", 32'(bready), 32'(eb));
    check("cpl_valid", 32'(gw_cpl_valid), 32'(occ != 0));
    ra = rvalid && er;
    ba = bvalid && eb;
    pop = (gw_cpl_ready && occ != 0) ? 1 : 0;
    if (ra) begin
      m = rresp > worst[rid] ? rresp : worst[rid];
      if (rlast) begin
        exp_q.push_back(mk(rid, 1'b0, m[1] || nbeats[rid] > 255, m, nbeats[rid] > 255 ? 255 : nbeats[rid]));
        nbeats[rid] = 0;
        worst[rid] = 2'b00;
      end else begin
        nbeats[rid]++;
        worst[rid] = m;
      end
    end
    if (ba) exp_q.push_back(mk(bid, 1'b1, bresp[1], bresp, 0));
    occ = occ + ((ra && rlast) ? 1 : 0) + (ba ? 1 : 0) - pop;
    if (rvalid && rlast && bvalid && fr) prio = !prio;
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input int max);
    bit ra, ba;
    for (int i = 0; i < max; i++) begin
      if (!rvalid && !bvalid) return;
      tick(ra, ba);
      if (ra) rvalid = 1'b0;
      if (ba) bvalid = 1'b0;
    end
    check("handshake_timeout", 32'({rvalid, bvalid}), 32'd0);
  endtask

  task automatic r_beat(input int id, input int resp, input bit last);
    rvalid = 1'b1;
    rid = TAG_W'(id);
    rresp = 2'(resp);
    rlast = last;
    run(64);
  endtask

  task automatic b_resp(input int id, input int resp);
    bvalid = 1'b1;
    bid = TAG_W'(id);
    bresp = 2'(resp);
    run(64);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    rvalid = 1'b0;
    bvalid = 1'b0;
    rlast = 1'b0;
    @(posedge aclk);
    #1;
    occ = 0;
    prio = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_TAGS; i++) begin
      nbeats[i] = 0;
      worst[i] = 2'b00;
    end
    @(negedge aclk);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_valid", 32'(gw_cpl_valid), 32'd0);
    check("rst_data", 32'(gw_cpl_data), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // monitor: every completion handed to the gateway must match the scoreboard head
  always @(negedge aclk) begin
    if (!areset && gw_cpl_valid && gw_cpl_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL cpl_unexpected: got %0h expected none", gw_cpl_data);
      end else check("cpl_data", 32'(gw_cpl_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bit ra, ba;
    do_reset();
    gw_cpl_ready = 1'b1;
    for (int i = 0; i < 4; i++) r_beat(3, 0, i == 3);
    check("rd4_valid", 32'(gw_cpl_valid), 32'd1);
    check("rd4_data", 32'(gw_cpl_data), 32'(mk(3, 1'b0, 1'b0, 2'd0, 3)));
    r_beat(5, 0, 0);
    r_beat(5, 2, 0);
    r_beat(5, 0, 1);
    check("rd_slverr", 32'(gw_cpl_data), 32'(mk(5, 1'b0, 1'b1, 2'd2, 2)));
    r_beat(5, 0, 1);
    check("rd_cleared", 32'(gw_cpl_data), 32'(mk(5, 1'b0, 1'b0, 2'd0, 0)));
    do_reset();
    gw_cpl_ready = 1'b0;
    for (int i = 0; i < 4; i++) b_resp(i, 0);
    bvalid = 1'b1;
    bid = 4'd4;
    rvalid = 1'b1;
    rid = 4'd6;
    rresp = 2'd1;
    rlast = 1'b0;
    tick(ra, ba);
    check("full_bready", 32'(bready), 32'd0);
    rlast = 1'b1;
    tick(ra, ba);
    check("full_rready_last", 32'(rready), 32'd0);
    gw_cpl_ready = 1'b1;
    tick(ra, ba);
    gw_cpl_ready = 1'b0;
    check("bready_after_pop", 32'(bready), 32'd1);
    gw_cpl_ready = 1'b1;
    run(32);
    for (int i = 0; i < 8; i++) tick(ra, ba);
    do_reset();
    gw_cpl_ready = 1'b1;
    rvalid = 1'b1;
    rid = 4'd1;
    rresp = 2'd0;
    rlast = 1'b1;
    bvalid = 1'b1;
    bid = 4'd2;
    bresp = 2'd0;
    tick(ra, ba);
    check("arb_b_first", 32'(gw_cpl_data), 32'(mk(2, 1'b1, 1'b0, 2'd0, 0)));
    if (ba) bvalid = 1'b0;
    tick(ra, ba);
    check("arb_r_second", 32'(gw_cpl_data), 32'(mk(1, 1'b0, 1'b0, 2'd0, 0)));
    if (ra) rvalid = 1'b0;
    rvalid = 1'b1;
    rid = 4'd3;
    bvalid = 1'b1;
    bid = 4'd4;
    bresp = 2'd3;
    tick(ra, ba);
    check("arb_r_after_flip", 32'(gw_cpl_data), 32'(mk(3, 1'b0, 1'b0, 2'd0, 0)));
    if (ra) rvalid = 1'b0;
    run(8);
    check("arb_b_after_flip", 32'(gw_cpl_data), 32'(mk(4, 1'b1, 1'b1, 2'd3, 0)));
    for (int i = 0; i < 3; i++) begin
      r_beat(1, 0, i == 2);
      r_beat(2, 1, i == 2);
    end
    check("interleave_tag2", 32'(gw_cpl_data), 32'(mk(2, 1'b0, 1'b0, 2'd1, 2)));
    r_beat(7, 3, 0);
    r_beat(7, 3, 0);
    do_reset();
    gw_cpl_ready = 1'b1;
    r_beat(7, 0, 1);
    check("after_reset_tag7", 32'(gw_cpl_data), 32'(mk(7, 1'b0, 1'b0, 2'd0, 0)));
    for (int n = 255; n <= 256; n++) begin
      rvalid = 1'b1;
      rid = 4'd9;
      rresp = 2'd0;
      rlast = 1'b0;
      for (int i = 0; i < n; i++) tick(ra, ba);
      rlast = 1'b1;
      run(8);
      check("sat_beats", 32'(gw_cpl_data), 32'(mk(9, 1'b0, n > 255, 2'd0, 255)));
    end
    for (int c = 0; c < 600; c++) begin
      if (!rvalid && $urandom_range(1, 0) == 1) begin
        rvalid = 1'b1;
        rid = TAG_W'($urandom_range(3, 0));
        rresp = 2'($urandom_range(3, 0));
        rlast = $urandom_range(2, 0) == 0;
      end
      if (!bvalid && $urandom_range(2, 0) == 0) begin
        bvalid = 1'b1;
        bid = TAG_W'($urandom_range(15, 0));
        bresp = 2'($urandom_range(3, 0));
      end
      gw_cpl_ready = $urandom_range(3, 0) != 0;
      tick(ra, ba);
      if (ra) rvalid = 1'b0;
      if (ba) bvalid = 1'b0;
    end
    gw_cpl_ready = 1'b1;
    run(64);
    for (int i = 0; i < 8; i++) tick(ra, ba);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
